// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester arbiter and sequencer for a single-port synchronous SRAM
//
// Purpose: grants one of two requesters a single read or write access at a time and
//          drives the SRAM pins from registers. Read data returns on the shared rdata
//          bus with a one-cycle rvalid pulse for the requester that issued the read.
// Ports:
//   Clk, Rst_n                   clock, asynchronous active-low reset
//   req0/1, we0/1                request (held until gnt), 1 = write / 0 = read
//   addr0/1, wdata0/1            access address and write data, valid while req high
//   gnt0/1                       one-cycle pulse, command is on the SRAM pins this cycle
//   rvalid0/1, rdata             one-cycle read-return pulse, shared read data
//   sram_CS/WE/RD                SRAM control strobes, high only in the issue cycle
//   sram_Addr, sram_dataIn       SRAM address and write data, hold last value
//   sram_dataOut                 SRAM read data, valid the cycle after the RD cycle
// Configuration:
//   SRAM_ARB_FIXED_PRIO_EN       defined: requester 0 always wins a tie
//                                undefined: round-robin between the two requesters
`timescale 1ns/1ps

module sram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              sram_CS,
    output logic              sram_WE,
    output logic              sram_RD,
    output logic [ADDR_W-1:0] sram_Addr,
    output logic [DATA_W-1:0] sram_dataIn,
    input  logic [DATA_W-1:0] sram_dataOut
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t state, state_nx;

    // Requester that owns the access in flight; steers the rvalid pulse.
    logic owner_q, owner_d;
    logic any_req;
    logic win;

    logic              gnt0_d, gnt1_d, rvalid0_d, rvalid1_d;
    logic              cs_d, we_d, rd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d, rdata_d;

    assign any_req = req0 | req1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign win = ~req0;
`else
    // Priority pointer names the requester that wins a tie.
    logic ptr_q, ptr_d;

    assign win = (req0 & req1) ? ptr_q : req1;
`endif

    // State register plus the registered outputs computed by the output process.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            owner_q     <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata       <= '0;
            sram_CS     <= 1'b0;
            sram_WE     <= 1'b0;
            sram_RD     <= 1'b0;
            sram_Addr   <= '0;
            sram_dataIn <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            owner_q     <= owner_d;
            gnt0        <= gnt0_d;
            gnt1        <= gnt1_d;
            rvalid0     <= rvalid0_d;
            rvalid1     <= rvalid1_d;
            rdata       <= rdata_d;
            sram_CS     <= cs_d;
            sram_WE     <= we_d;
            sram_RD     <= rd_d;
            sram_Addr   <= addr_d;
            sram_dataIn <= din_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    // Next-state logic. sram_WE still holds the latched command type during ISSUE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   state_nx = sram_WE ? IDLE : CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: next values for every registered output.
    always_comb begin
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        rd_d      = 1'b0;
        addr_d    = sram_Addr;
        din_d     = sram_dataIn;
        rdata_d   = rdata;
        owner_d   = owner_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state)
            IDLE: begin
                // Latch the winner's command straight into the pin registers so
                // it executes even if the requester drops req afterwards.
                if (any_req) begin
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    cs_d    = 1'b1;
                    we_d    = win ? we1 : we0;
                    rd_d    = ~(win ? we1 : we0);
                    addr_d  = win ? addr1 : addr0;
                    din_d   = win ? wdata1 : wdata0;
                    owner_d = win;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    ptr_d   = ~win;
`endif
                end
            end
            CAPTURE: begin
                rdata_d   = sram_dataOut;
                rvalid0_d = ~owner_q;
                rvalid1_d = owner_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with SRAM model and read scoreboard
`timescale 1ns/1ps

module tb_sram_arbiter;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       sram_CS, sram_WE, sram_RD;
    logic [7:0] sram_Addr, sram_dataIn;
    logic [7:0] sram_dataOut = '0;

    int checks = 0;
    int fails  = 0;

    sram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata),
        .sram_CS(sram_CS), .sram_WE(sram_WE), .sram_RD(sram_RD),
        .sram_Addr(sram_Addr), .sram_dataIn(sram_dataIn),
        .sram_dataOut(sram_dataOut)
    );

    always #5 Clk = ~Clk;

    // Synchronous single-port SRAM: read data appears after the RD edge and is held.
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge Clk) begin
        if (sram_CS && sram_WE) mem[sram_Addr] <= sram_dataIn;
        if (sram_CS && sram_RD) sram_dataOut <= mem[sram_Addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       port;
        logic [7:0] data;
    } rd_exp_t;
    rd_exp_t sbq[$];

    // Read-return scoreboard and one-hot monitors.
    initial forever begin
        @(posedge Clk);
        #1;
        if (rvalid0 || rvalid1) begin
            if (sbq.size() == 0) begin
                check("rvalid_spurious", {30'd0, rvalid1, rvalid0}, 32'd0);
            end else begin
                rd_exp_t e;
                e = sbq.pop_front();
                check("rvalid_port", {30'd0, rvalid1, rvalid0}, e.port ? 32'd2 : 32'd1);
                check("rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
        if (gnt0 && gnt1) check("gnt_exclusive", {30'd0, gnt1, gnt0}, 32'd1);
    end

    function automatic logic [30:0] all_outs();
        return {gnt0, gnt1, rvalid0, rvalid1, sram_CS, sram_WE, sram_RD,
                sram_Addr, sram_dataIn, rdata};
    endfunction

    task automatic do_op(input logic port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd);
        int  n;
        logic g;
        @(negedge Clk);
        if (!port) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
        else       begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
        n = 0;
        g = 1'b0;
        while (!g && n < 20) begin
            @(posedge Clk);
            #1;
            g = port ? gnt1 : gnt0;
            n++;
        end
        check("gnt_seen", {31'd0, g}, 32'd1);
        if (!port) req0 = 1'b0; else req1 = 1'b0;
        if (g) begin
            check("issue_pins", {13'd0, sram_CS, sram_WE, sram_RD, sram_Addr, sram_dataIn},
                  {13'd0, 1'b1, we, ~we, addr, wd});
            check("gnt_other", {31'd0, port ? gnt0 : gnt1}, 32'd0);
            if (!we) sbq.push_back('{port, exp_rd});
            @(posedge Clk);
            #1;
            check("post_issue_ctl", {29'd0, sram_CS, sram_WE, sram_RD}, 32'd0);
            if (!we) begin
                @(posedge Clk);
                #1;
                check("rvalid_at_T2", {31'd0, port ? rvalid1 : rvalid0}, 32'd1);
            end
        end
    endtask

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        ng;
        int        cyc;
        int        n;
        logic [3:0] seq;
        logic [3:0] exp_seq;

        vecs[0] = '{1'b0, 1'b1, 8'h03, 8'h06, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h03, 8'h00, 8'h06};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'hAA, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hAA};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h5A, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 8'h80, 8'hC3, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A};
        vecs[7] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'hC3};
        vecs[8] = '{1'b1, 1'b1, 8'h03, 8'h77, 8'h00};
        vecs[9] = '{1'b0, 1'b0, 8'h03, 8'h00, 8'h77};

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_outputs", {1'b0, all_outs()}, 32'd0);
        Rst_n = 1'b1;

        // Reset asserted mid-access clears every output at once.
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h44; wdata0 = 8'h99;
        @(posedge Clk);
        #1;
        check("pre_reset_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {1'b0, all_outs()}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check("idle_ctl_after_reset", {29'd0, sram_CS, sram_WE, sram_RD}, 32'd0);
        end

        // Both requesters held high: grant pattern from a fresh pointer.
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h22;
        ng = 0;
        cyc = 0;
        seq = 4'b0000;
        while (ng < 4 && cyc < 40) begin
            @(posedge Clk);
            #1;
            if (gnt0 || gnt1) begin
                seq[ng] = gnt1;
                ng++;
            end
            cyc++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_seq = 4'b0000;
`else
        exp_seq = 4'b1010;
`endif
        check("both_req_grant_count", ng, 32'd4);
        check("both_req_grant_seq", {28'd0, seq}, {28'd0, exp_seq});
        repeat (2) @(posedge Clk);

        // Table of single-requester accesses.
        for (int i = 0; i < 10; i++)
            do_op(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
        repeat (2) @(posedge Clk);

        // Reset during CAPTURE drops the read; the next tie goes to requester 0.
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'hFF;
        n = 0;
        while (!gnt0 && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("capture_rst_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        check("capture_rst_outputs", {1'b0, all_outs()}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check("no_rvalid_after_rst", {30'd0, rvalid1, rvalid0}, 32'd0);
        end
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h31;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 8'h41;
        n = 0;
        while (!(gnt0 || gnt1) && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("first_gnt_after_rst", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("scoreboard_drained", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
